// File: rtl/clk_ctrl_pkg.sv
// Shared types and default parameters for the clock/step controller.
// The state encoding is visible on the debug port, so keep these values stable.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NUM_BP = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_DIV_W  = 24;

  // A breakpoint index needs at least one bit, even when there is a single comparator.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Run-rate prescaler: asserts tick once every div+1 clocks while clear is low.
// A counter left above a newly lowered div wraps to 0 without ticking.
module tick_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clear && (cnt_q == div);
    cnt_d = (clear || (cnt_q >= div)) ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_step_controller.sv
// Debug clock controller: gates a CPU clock-enable for free run, counted step
// bursts and hardware breakpoints, and counts every enable pulse it issues.
module clock_step_controller
  import clk_ctrl_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int NUM_BP = DEF_NUM_BP,
  parameter  int CNT_W  = DEF_CNT_W,
  parameter  int DIV_W  = DEF_DIV_W,
  localparam int IDX_W  = idx_width(NUM_BP)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run_en,
  input  logic                          step,
  input  logic [CNT_W-1:0]              step_count,
  input  logic [DIV_W-1:0]              div,
  input  logic [ADDR_W-1:0]             pc,
  input  logic [NUM_BP-1:0][ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]             bp_valid,
  input  logic                          cycle_clr,
  output logic                          core_en,
  output state_e                        state,
  output logic                          bp_hit,
  output logic [IDX_W-1:0]              bp_index,
  output logic [CNT_W-1:0]              cycle_count
);

  state_e           state_q, state_d;
  logic             step_prev_q, step_prev_d;
  logic             step_arm_q, step_arm_d;
  logic             step_req_q, step_req_d;
  logic             first_q, first_d;
  logic             core_en_q, core_en_d;
  logic [IDX_W-1:0] bp_index_q, bp_index_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic             active, tick, fire, bp_match;
  logic [IDX_W-1:0] match_idx;
  logic [CNT_W-1:0] step_load;

  // The arm flag only sets once step has been seen low, so a step held
  // through reset cannot masquerade as a fresh rising edge.
  always_comb begin
    step_prev_d = step;
    step_arm_d  = step_arm_q | ~step;
    step_req_d  = step & ~step_prev_q & step_arm_q;
  end

  assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign step_load = (step_count == '0) ? CNT_W'(1) : step_count;

  tick_divider #(.DIV_W(DIV_W)) u_tick_divider (
    .clk   (clk),
    .rst   (rst),
    .clear (~active),
    .div   (div),
    .tick  (tick)
  );

  // Scan downwards so the lowest matching comparator is the one reported.
  always_comb begin
    bp_match  = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_valid[i] && (bp_addr[i] == pc)) begin
        bp_match  = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HALT;
      step_prev_q   <= 1'b0;
      step_arm_q    <= 1'b0;
      step_req_q    <= 1'b0;
      first_q       <= 1'b1;
      core_en_q     <= 1'b0;
      bp_index_q    <= '0;
      remaining_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      step_prev_q   <= step_prev_d;
      step_arm_q    <= step_arm_d;
      step_req_q    <= step_req_d;
      first_q       <= first_d;
      core_en_q     <= core_en_d;
      bp_index_q    <= bp_index_d;
      remaining_q   <= remaining_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    bp_index_d  = bp_index_q;
    fire        = 1'b0;
    case (state_q)
      ST_HALT: begin
        first_d = 1'b1;
        if (run_en) begin
          state_d = ST_RUN;
        end else if (step_req_q) begin
          state_d     = ST_STEP;
          remaining_d = step_load;
        end
      end
      ST_RUN: begin
        if (!run_en) begin
          state_d = ST_HALT;
        end else if (tick) begin
          first_d = 1'b0;
          if (bp_match && !first_q) begin
            state_d    = ST_BREAK;
            bp_index_d = match_idx;
          end else begin
            fire = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if (tick) begin
          first_d = 1'b0;
          if (bp_match && !first_q) begin
            state_d    = ST_BREAK;
            bp_index_d = match_idx;
          end else begin
            fire        = 1'b1;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q <= CNT_W'(1)) state_d = ST_HALT;
          end
        end
      end
      ST_BREAK: begin
        first_d = 1'b1;
        if (step_req_q) begin
          state_d     = ST_STEP;
          remaining_d = step_load;
        end else if (!run_en) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    core_en_d     = fire;
    cycle_count_d = cycle_clr ? '0 : cycle_count_q + CNT_W'(fire);
  end

  always_comb begin
    core_en     = core_en_q;
    state       = state_q;
    bp_hit      = (state_q == ST_BREAK);
    bp_index    = bp_index_q;
    cycle_count = cycle_count_q;
  end

endmodule

// File: doc/clock_step_controller.md
CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the CPU program-counter address.
REQ-002 SHALL have parameter NUM_BP, default 4, number of hardware breakpoint comparators (1..8).
REQ-003 SHALL have parameter CNT_W, default 16, width of the step count and the cycle counter.
REQ-004 SHALL have parameter DIV_W, default 24, width of the run-rate divider.
REQ-005 SHALL have port: clk  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: run_en  in  1  level; high requests free run.
REQ-008 SHALL have port: step  in  1  level from the probe bus; each rising edge requests a step burst.
REQ-009 SHALL have port: step_count  in  CNT_W  core-enable pulses per burst; 0 is treated as 1.
REQ-010 SHALL have port: div  in  DIV_W  tick period minus 1 (0 = tick every clk).
REQ-011 SHALL have port: pc  in  ADDR_W  current CPU program counter.
REQ-012 SHALL have port: bp_addr  in  NUM_BP x ADDR_W  breakpoint addresses.
REQ-013 SHALL have port: bp_valid  in  NUM_BP  per-comparator enable.
REQ-014 SHALL have port: cycle_clr  in  1  synchronously clears cycle_count.
REQ-015 SHALL have port: core_en  out  1  registered one-clk CPU clock-enable pulse.
REQ-016 SHALL have port: state  out  2  current FSM state (package enum).
REQ-017 SHALL have port: bp_hit  out  1  high while in BREAK.
REQ-018 SHALL have port: bp_index  out  clog2(NUM_BP), minimum 1  index of the comparator that caused the break.
REQ-019 SHALL have port: cycle_count  out  CNT_W  total core_en pulses issued; wraps modulo 2^CNT_W.

Function
REQ-020 SHALL implement states HALT, RUN, STEP and BREAK.
REQ-021 SHALL register a step rising edge as step_req in the following clk; step_req is valid for one cycle only.
REQ-022 HALT: run_en=1 -> RUN; else step_req -> STEP, loading remaining=max(step_count,1); if both occur in the same cycle, RUN wins and step_req is dropped.
REQ-023 SHALL clear the divider counter on entry to RUN/STEP; tick asserts when counter==div, then counter returns to 0; the counter is held at 0 outside RUN/STEP.
REQ-024 RUN/STEP: on a tick with no breakpoint match, core_en=1 in the next clk and cycle_count increments in that same cycle.
REQ-025 STEP: remaining decrements per issued pulse; after the pulse that brings it to 0 -> HALT.
REQ-026 RUN: run_en=0 -> HALT in the next clk, with no further pulses; step_req in RUN is ignored.
REQ-027 STEP: run_en is ignored until the burst completes.
REQ-028 Match = bp_valid[i] && bp_addr[i]==pc, evaluated on a tick; the lowest matching index wins.
REQ-029 On a match, no pulse is issued; go to BREAK and latch bp_index.
REQ-030 Skip-first rule: the first tick after entering RUN or STEP ignores breakpoints, so execution resumes from a breakpointed pc.
REQ-031 BREAK: step_req -> STEP (loads remaining); run_en=0 -> HALT; bp_hit clears on exit; bp_index holds its value until the next break.
REQ-032 cycle_clr SHALL take priority over a same-cycle increment, giving cycle_count=0.
REQ-033 A div change mid-run takes effect at the next compare; a counter value above the new div SHALL wrap to 0 without a tick.

Reset
REQ-034 On rst=1 at a clk edge: state=HALT, core_en=0, bp_hit=0, bp_index=0, cycle_count=0, remaining=0, divider=0, step edge history=0.
REQ-035 Reset mid-burst or mid-run SHALL abort with no further pulses; a step held high through reset SHALL NOT generate step_req after release.

Structure
REQ-036 Package clk_ctrl_pkg SHALL hold the state enum (HALT=0, RUN=1, STEP=2, BREAK=3) and default parameter constants.
REQ-037 Sub-module tick_divider (DIV_W, clear, div -> tick) SHALL implement the prescaler; the breakpoint compare stays inline.

Verification
REQ-038 div=0, step_count=3, step pulse -> exactly 3 consecutive core_en pulses, state returns to HALT, cycle_count=3.
REQ-039 div=4, run_en=1 for 50 clk -> pulses 5 clk apart, no pulse after run_en falls, state HALT.
REQ-040 bp_addr[2]=0x10, bp_valid=4'b0100, pc reaches 0x10 in RUN -> BREAK, bp_index=2, core_en stays 0; run_en toggle 0->1 resumes with one pulse at pc=0x10.
REQ-041 bp0 and bp3 both equal pc -> bp_index=0; step_count=0 -> exactly 1 pulse.
REQ-042 rst asserted in cycle 2 of a 10-step burst -> no further pulses, all outputs at reset values, step held high yields no burst.
REQ-043 cycle_count=0xFFFF plus one pulse -> 0x0000; cycle_clr coincident with a pulse -> 0.
